// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA box bus master.
package rsa_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_KEY  = 2'd1,
    OP_ENC  = 2'd2,
    OP_DEC  = 2'd3
  } rsa_op_t;

  localparam int unsigned KEY_WORDS    = 4;
  localparam int unsigned ENC_WORDS    = 5;
  localparam int unsigned DEC_WORDS    = 12;
  localparam int unsigned RESULT_WORDS = 4;
  localparam int unsigned PAYLOAD_W    = 384;
  localparam int unsigned RESULT_W     = 128;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_OP,
    S_WR_DATA,
    S_WAIT,
    S_RD_ISSUE,
    S_RD_CAPTURE,
    S_RESP
  } rsa_state_t;

  function automatic logic [3:0] op_words(input rsa_op_t op);
    case (op)
      OP_KEY:  return 4'(KEY_WORDS);
      OP_ENC:  return 4'(ENC_WORDS);
      OP_DEC:  return 4'(DEC_WORDS);
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/rsa_bus_master_if.sv
// Command/response handshake plus the 32-bit slave bus of the RSA bus master.
interface rsa_bus_master_if
  import rsa_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) ();

  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_op;
  logic [PAYLOAD_W-1:0] req_payload;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [RESULT_W-1:0]  rsp_data;
  logic                 rsp_err;
  logic                 busy;

  logic                 chipselect;
  logic                 write;
  logic [ADDR_W-1:0]    address;
  logic [DATA_W-1:0]    writedata;
  logic [DATA_W-1:0]    readdata;

  modport master (
    input  req_valid, req_op, req_payload, rsp_ready, readdata,
    output req_ready, rsp_valid, rsp_data, rsp_err, busy,
           chipselect, write, address, writedata
  );

  modport slave (
    output req_valid, req_op, req_payload, rsp_ready, readdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err, busy,
           chipselect, write, address, writedata
  );

endinterface

// File: rtl/rsa_bus_master.sv
// Serializes one wide RSA command onto the slave bus and reads back the 128-bit result.
// Optional cycle counter output perf_cycles when RSA_MASTER_PERF_EN is defined.
module rsa_bus_master
  import rsa_pkg::*;
#(
  parameter int unsigned RESULT_WAIT = 2,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DATA_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  rsa_bus_master_if.master bus
`ifdef RSA_MASTER_PERF_EN
  ,
  output logic [15:0]      perf_cycles
`endif
);

  rsa_state_t           state_q, state_d;
  rsa_op_t              op_q, op_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [3:0]           nwords_q, nwords_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [RESULT_W-1:0]  result_q, result_d;
  logic                 err_q, err_d;
  logic                 accept;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_NONE;
      payload_q <= '0;
      nwords_q  <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      payload_q <= payload_d;
      nwords_q  <= nwords_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      err_q     <= err_d;
    end
  end

  // Payload and result move through shift registers so every bus cycle
  // touches only the low payload word / top result word.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    payload_d = payload_q;
    nwords_d  = nwords_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    err_d     = err_q;
    accept    = 1'b0;

    bus.req_ready  = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.address    = '0;
    bus.writedata  = '0;

    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept    = 1'b1;
          op_d      = rsa_op_t'(bus.req_op);
          payload_d = bus.req_payload;
          nwords_d  = op_words(rsa_op_t'(bus.req_op));
          err_d     = (rsa_op_t'(bus.req_op) == OP_NONE);
          result_d  = '0;
          cnt_d     = '0;
          state_d   = (rsa_op_t'(bus.req_op) == OP_NONE) ? S_RESP : S_WR_OP;
        end
      end
      S_WR_OP: begin
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.writedata  = DATA_W'(op_q);
        cnt_d          = 8'd1;
        state_d        = S_WR_DATA;
      end
      S_WR_DATA: begin
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = ADDR_W'(cnt_q[3:0]);
        bus.writedata  = payload_q[DATA_W-1:0];
        payload_d      = {{DATA_W{1'b0}}, payload_q[PAYLOAD_W-1:DATA_W]};
        if (cnt_q[3:0] == nwords_q) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'(RESULT_WAIT - 1)) begin
          cnt_d   = '0;
          state_d = S_RD_ISSUE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RD_ISSUE: begin
        bus.chipselect = 1'b1;
        bus.address    = ADDR_W'(cnt_q[1:0]);
        state_d        = S_RD_CAPTURE;
      end
      S_RD_CAPTURE: begin
        result_d = {bus.readdata, result_q[RESULT_W-1:DATA_W]};
        if (cnt_q[1:0] == 2'(RESULT_WORDS - 1)) begin
          cnt_d   = '0;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = S_RD_ISSUE;
        end
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.rsp_data = result_q;
  assign bus.rsp_err  = err_q;

`ifdef RSA_MASTER_PERF_EN
  logic [15:0] perf_q;
  logic        counting_q;

  // Counts through the first RESP cycle, then freezes until the next command.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_q     <= '0;
      counting_q <= 1'b0;
    end else if (accept) begin
      perf_q     <= '0;
      counting_q <= 1'b1;
    end else if (counting_q) begin
      if (perf_q != '1) perf_q <= perf_q + 16'd1;
      if (state_q == S_RESP) counting_q <= 1'b0;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: doc/rsa_bus_master.md
Name: rsa_bus_master

Overview:
- Hardware initiator for the RSA box's 32-bit memory-mapped slave interface.
- Accepts one wide command per handshake: op plus a payload of up to 384 bits.
- Serializes the command into chipselect/write transactions: the instruction word at address 0, then payload words at addresses 1..N.
- Waits for the ALU, reads the 128-bit result back as four 32-bit words, and returns it on a valid/ready response port. Replaces software driving the slave word by word.

Parameters:
- RESULT_WAIT, 2: idle cycles between the last payload write and the first result read; must be ≥2.
- ADDR_W, 4: slave address width.
- DATA_W, 32: slave data width; fixed at 32.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when high together with req_valid
- req_op  in  2  1=key, 2=encrypt, 3=decrypt, 0=illegal
- req_payload  in  384  payload; word k (k=1..N) = req_payload[32k-1:32(k-1)]
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumed
- rsp_data  out  128  result; word i from address i at [32i+31:32i]
- rsp_err  out  1  set with rsp_valid for an illegal op
- busy  out  1  high in every state except IDLE
- chipselect  out  1  slave select
- write  out  1  1=write, 0=read (valid only with chipselect)
- address  out  ADDR_W  slave word address
- writedata  out  32  slave write data
- readdata  in  32  slave read data, registered by the slave one cycle after the read cycle

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; all outputs 0, except req_ready=1 is driven from the cycle after reset; internal registers cleared. Reset mid-operation aborts immediately: chipselect is low in the next cycle, and no partial response is produced.
- Word count N: key=4, encrypt=5, decrypt=12. Op and payload are captured at acceptance; later changes to req_* are ignored.
- States: IDLE → WR_OP → WR_DATA → WAIT → RD_ISSUE ⇄ RD_CAPTURE → RESP → IDLE.
- IDLE: req_ready=1. Handshake (cycle 0) → WR_OP for a legal op. For op 0, go straight to RESP with rsp_data=0 and rsp_err=1; no bus traffic.
- WR_OP (cycle 1): chipselect=1, write=1, address=0, writedata={30'b0, op}.
- WR_DATA (cycles 2..N+1): one write per cycle at address k=1..N with word k. Strictly ascending; no gaps.
- WAIT: chipselect=0 for exactly RESULT_WAIT cycles.
- RD_ISSUE: chipselect=1, write=0, address=i (i=0..3).
- RD_CAPTURE: chipselect=0; readdata is latched into rsp_data word i. After i=3 → RESP, else i+1 → RD_ISSUE.
- RESP: rsp_valid=1; rsp_data and rsp_err are held stable until rsp_ready. On handshake → IDLE.
- Throughput: req_ready is low during RESP, so at least one IDLE cycle separates consecutive commands.
- Latency, legal op: rsp_valid first high in cycle N+RESULT_WAIT+10 (key 16, encrypt 17, decrypt 24 with default RESULT_WAIT). Illegal op: cycle 1.
- In every cycle with chipselect=0, write, address and writedata are driven to 0.
- rsp_err clears on the next accepted command.

Optional Feature:
- Macro: RSA_MASTER_PERF_EN.
- Defined: adds output perf_cycles[15:0]. The counter clears on command acceptance, increments every cycle until rsp_valid first rises, and saturates at 16'hFFFF. It holds its value until the next acceptance and resets to 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package rsa_pkg holds:
  - the rsa_op_t enum (OP_NONE=0, OP_KEY=1, OP_ENC=2, OP_DEC=3);
  - word-count constants KEY_WORDS=4, ENC_WORDS=5, DEC_WORDS=12, RESULT_WORDS=4;
  - payload/result width constants 384 and 128;
  - the state enum.
- Single module; no sub-module is warranted. The bench pairs it with the existing slave.

Test Plan:
- Key op, payload[63:0]=3, payload[127:64]=5, RESULT_WAIT=2, real slave → writes at addresses 0,1,2,3,4 in cycles 1..5; rsp_valid in cycle 16; rsp_data=128'd15; rsp_err=0.
- Encrypt op, payload words 1..5 = 32'hA0..32'hA4 → writedata sequence 2, A0, A1, A2, A3, A4 at addresses 0..5; rsp_data=128'd1 in cycle 17.
- Decrypt op, 12 words 32'h1..32'hC → 13 back-to-back writes (address 12 last); rsp_data=128'd2 in cycle 24.
- Illegal op 0 → no chipselect ever asserted; rsp_valid in cycle 1; rsp_err=1; rsp_data=0.
- Backpressure: rsp_ready held low 5 cycles after rsp_valid → rsp_data stable; req_ready=0 throughout; IDLE and req_ready=1 the cycle after the handshake.
- Reset low in cycle 3 of a key op → chipselect=0 and busy=0 from cycle 4; no rsp_valid. A following key op completes with the correct result. With RSA_MASTER_PERF_EN, perf_cycles=16 after the first key op.
